dmem_responder: RTL and testbench

Data-memory responder for the pipelined core's Memory stage: the target side of the core's load/store request interface. It accepts one request at a time over a valid/ready handshake and models configurable access latency with a wait-state FSM. It performs byte/half/word stores with byte-lane enables, and returns loads sign- or zero-extended. The hazard logic stalls the core's M stage while a request is outstanding.

---
 rtl/dmem_responder_pkg.sv | 18 +
 rtl/dmem_responder_lane_unit.sv | 58 +++++
 rtl/dmem_responder.sv | 185 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and defaults for the data-memory responder.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } dmem_state_e;

  localparam int unsigned DMEM_DEPTH_WORDS = 256;

endpackage

// File: rtl/dmem_responder_lane_unit.sv
// Combinational access decode: error check, store byte enables and lane
// alignment, and load extraction with sign/zero extension.
module dmem_responder_lane_unit
  import dmem_responder_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS
) (
  input  logic [XLEN-1:0] addr_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [31:0]     rword_i,
  output logic            err_o,
  output logic [3:0]      be_o,
  output logic [31:0]     wword_o,
  output logic [XLEN-1:0] rdata_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        out_of_range;

  assign out_of_range = (addr_i >> 2) >= XLEN'(DEPTH_WORDS);
  assign byte_v       = 8'(rword_i >> {addr_i[1:0], 3'b000});
  assign half_v       = 16'(rword_i >> {addr_i[1], 4'b0000});

  always_comb begin
    err_o   = 1'b1;
    be_o    = 4'b0000;
    wword_o = 32'h0;
    rdata_o = '0;
    unique case (size_i)
      MEM_B: begin
        err_o   = out_of_range;
        be_o    = 4'b0001 << addr_i[1:0];
        wword_o = {4{wdata_i[7:0]}};
        rdata_o = {{(XLEN-8){byte_v[7] & ~unsigned_i}}, byte_v};
      end
      MEM_H: begin
        err_o   = out_of_range | addr_i[0];
        be_o    = 4'b0011 << {addr_i[1], 1'b0};
        wword_o = {2{wdata_i[15:0]}};
        rdata_o = {{(XLEN-16){half_v[15] & ~unsigned_i}}, half_v};
      end
      MEM_W: begin
        err_o   = out_of_range | (addr_i[1:0] != 2'b00);
        be_o    = 4'b1111;
        wword_o = wdata_i[31:0];
        rdata_o = XLEN'(rword_i);
      end
      default: begin
        err_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, LATENCY wait states, byte-lane
// stores and extended loads, response held until the core takes it.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter int unsigned LATENCY     = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  dmem_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;

  logic [31:0]     mem_q [DEPTH_WORDS];

  logic            in_idle;
  logic            acc_we;
  logic [XLEN-1:0] acc_addr;
  logic [XLEN-1:0] acc_wdata;
  logic [1:0]      acc_size;
  logic            acc_uns;
  logic [IdxW-1:0] acc_idx;
  logic            commit;
  logic            mem_we;

  logic            lane_err;
  logic [3:0]      lane_be;
  logic [31:0]     lane_wword;
  logic [XLEN-1:0] lane_rdata;

  // In IDLE the lane unit sees the live request so a zero-latency access can
  // commit on its accept edge; afterwards it sees the latched copy.
  assign in_idle   = (state_q == IDLE);
  assign acc_we    = in_idle ? req_we       : we_q;
  assign acc_addr  = in_idle ? req_addr     : addr_q;
  assign acc_wdata = in_idle ? req_wdata    : wdata_q;
  assign acc_size  = in_idle ? req_size     : size_q;
  assign acc_uns   = in_idle ? req_unsigned : uns_q;
  assign acc_idx   = acc_addr[2 +: IdxW];

  dmem_responder_lane_unit #(
    .XLEN        (XLEN),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_lane (
    .addr_i     (acc_addr),
    .size_i     (acc_size),
    .unsigned_i (acc_uns),
    .wdata_i    (acc_wdata),
    .rword_i    (mem_q[acc_idx]),
    .err_o      (lane_err),
    .be_o       (lane_be),
    .wword_o    (lane_wword),
    .rdata_o    (lane_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          uns_d   = req_unsigned;
          err_d   = lane_err;
          rdata_d = '0;
          if (lane_err) begin
            state_d = RESP;
          end else if (LATENCY == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CntW'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (commit && !acc_we) begin
      rdata_d = lane_rdata;
    end

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // A reset on the commit edge aborts the store along with the FSM.
  assign mem_we = commit && acc_we && !reset;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_be[b]) begin
          mem_q[acc_idx][8*b +: 8] <= lane_wword[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 and LATENCY=0 instances against a
// byte-array reference model, directed cases then random traffic.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic        rsp_ready = 1'b0;
  bit          sel = 1'b0;

  logic        rv0, rv1, rr0, rr1;
  logic        req_ready0, req_ready1, rsp_valid0, rsp_valid1, rsp_err0, rsp_err1;
  logic [31:0] rsp_rdata0, rsp_rdata1;
  logic        rq_m, rv_m, er_m;
  logic [31:0] rd_m;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem_m [2][1024];

  always #5 clk = ~clk;

  assign rv0  = req_valid && !sel;
  assign rv1  = req_valid && sel;
  assign rr0  = rsp_ready && !sel;
  assign rr1  = rsp_ready && sel;
  assign rq_m = sel ? req_ready1 : req_ready0;
  assign rv_m = sel ? rsp_valid1 : rsp_valid0;
  assign er_m = sel ? rsp_err1   : rsp_err0;
  assign rd_m = sel ? rsp_rdata1 : rsp_rdata0;

  dmem_responder #(.XLEN(32), .DEPTH_WORDS(256), .LATENCY(2)) u_dut0 (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (rv0),
    .req_ready    (req_ready0),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .rsp_valid    (rsp_valid0),
    .rsp_ready    (rr0),
    .rsp_rdata    (rsp_rdata0),
    .rsp_err      (rsp_err0)
  );

  dmem_responder #(.XLEN(32), .DEPTH_WORDS(256), .LATENCY(0)) u_dut1 (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (rv1),
    .req_ready    (req_ready1),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .rsp_valid    (rsp_valid1),
    .rsp_ready    (rr1),
    .rsp_rdata    (rsp_rdata1),
    .rsp_err      (rsp_err1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Little-endian byte-array model of one responder's storage.
  function automatic void model_op(input int d, input logic we, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [1:0] sz,
                                   input logic u, output logic [31:0] rd, output logic er);
    int nb;
    logic [31:0] v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    er = (sz == 2'd3) || ((a % nb) != 0) || ((a / 4) >= 256);
    rd = '0;
    if (er) return;
    if (we) begin
      for (int i = 0; i < nb; i++) mem_m[d][int'(a) + i] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < nb; i++) v = v | (32'(mem_m[d][int'(a) + i]) << (8 * i));
      if (!u && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      rd = v;
    end
  endfunction

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic u);
    req_we       = we;
    req_addr     = a;
    req_wdata    = wd;
    req_size     = sz;
    req_unsigned = u;
    req_valid    = 1'b1;
  endtask

  task automatic wait_accept(output bit ok);
    int n = 0;
    while (!rq_m && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = rq_m;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rv_m && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] sz, input logic u,
                      output logic [31:0] rd, output logic er, output int lat);
    bit ok;
    drive(we, a, wd, sz, u);
    wait_accept(ok);
    wait_rsp(lat);
    if (!ok) lat = 99;
    rd = rd_m;
    er = er_m;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] sz, input logic u,
                        output logic [31:0] rd);
    logic [31:0] exp_rd;
    logic        exp_er, er;
    int          lat, exp_lat;
    model_op(int'(sel), we, a, wd, sz, u, exp_rd, exp_er);
    xact(we, a, wd, sz, u, rd, er, lat);
    exp_lat = (exp_er || sel) ? 1 : 3;
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, 32'(er), 32'(exp_er));
    check({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic init_mem();
    logic [31:0] rd;
    for (int w = 0; w < 256; w++) run_op("init", 1'b1, 32'(w * 4), 32'h0, 2'd2, 1'b0, rd);
  endtask

  task automatic reset_during_store(input logic commits);
    logic [31:0] rd, dummy;
    logic        de;
    bit          ok;
    drive(1'b1, 32'h40, 32'h55, 2'd2, 1'b0);
    wait_accept(ok);
    check("rst_accept", 32'(ok), 32'd1);
    if (commits) model_op(int'(sel), 1'b1, 32'h40, 32'h55, 2'd2, 1'b0, dummy, de);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_req_ready", 32'(rq_m), 32'd1);
    check("rst_mid_rsp_valid", 32'(rv_m), 32'd0);
    check("rst_mid_rdata", rd_m, 32'h0);
    check("rst_mid_err", 32'(er_m), 32'd0);
    run_op("rst_ld", 1'b0, 32'h40, 32'h0, 2'd2, 1'b0, rd);
    check("rst_ld_const", rd, commits ? 32'h55 : 32'h0);
  endtask

  task automatic random_ops(input int n);
    logic [31:0] rd, a;
    for (int i = 0; i < n; i++) begin
      a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      run_op("rand", 1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), rd);
    end
  endtask

  initial begin
    logic [31:0] rd, exp_rd;
    logic        exp_er;
    int          lat;
    bit          ok;

    for (int d = 0; d < 2; d++) for (int i = 0; i < 1024; i++) mem_m[d][i] = 8'h00;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_req_ready0", 32'(req_ready0), 32'd1);
    check("reset_rsp_valid0", 32'(rsp_valid0), 32'd0);
    check("reset_rdata0", rsp_rdata0, 32'h0);
    check("reset_err0", 32'(rsp_err0), 32'd0);
    check("reset_req_ready1", 32'(req_ready1), 32'd1);
    check("reset_rsp_valid1", 32'(rsp_valid1), 32'd0);

    // LATENCY = 2 instance
    sel = 1'b0;
    init_mem();
    run_op("sw10", 1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0, rd);
    run_op("lw10", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, rd);
    check("lw10_const", rd, 32'hDEAD_BEEF);
    run_op("sb13", 1'b1, 32'h13, 32'h80, 2'd0, 1'b0, rd);
    run_op("lb13", 1'b0, 32'h13, 32'h0, 2'd0, 1'b0, rd);
    check("lb13_const", rd, 32'hFFFF_FF80);
    run_op("lbu13", 1'b0, 32'h13, 32'h0, 2'd0, 1'b1, rd);
    check("lbu13_const", rd, 32'h0000_0080);
    run_op("lw10b", 1'b0, 32'h10, 32'h0, 2'd2, 1'b1, rd);
    check("lw10b_const", rd, 32'h80AD_BEEF);
    run_op("sw20", 1'b1, 32'h20, 32'h0, 2'd2, 1'b0, rd);
    run_op("sh22", 1'b1, 32'h22, 32'h1234_ABCD, 2'd1, 1'b0, rd);
    run_op("lh22", 1'b0, 32'h22, 32'h0, 2'd1, 1'b0, rd);
    check("lh22_const", rd, 32'hFFFF_ABCD);
    run_op("lhu20", 1'b0, 32'h20, 32'h0, 2'd1, 1'b1, rd);
    check("lhu20_const", rd, 32'h0);
    run_op("lw11", 1'b0, 32'h11, 32'h0, 2'd2, 1'b0, rd);
    run_op("sh21", 1'b1, 32'h21, 32'hFFFF_FFFF, 2'd1, 1'b0, rd);
    run_op("sz3", 1'b1, 32'h20, 32'hFFFF_FFFF, 2'd3, 1'b0, rd);
    run_op("oor", 1'b1, 32'h400, 32'hFFFF_FFFF, 2'd2, 1'b0, rd);
    run_op("lw20", 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, rd);
    check("lw20_const", rd, 32'hABCD_0000);

    // Backpressure: response held while a new request waits.
    model_op(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, exp_rd, exp_er);
    drive(1'b0, 32'h10, 32'h0, 2'd2, 1'b0);
    wait_accept(ok);
    wait_rsp(lat);
    check("bp_lat", lat, 3);
    drive(1'b1, 32'h30, 32'h77, 2'd2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", 32'(rv_m), 32'd1);
      check("bp_rdata", rd_m, exp_rd);
      check("bp_err", 32'(er_m), 32'd0);
      check("bp_req_ready", 32'(rq_m), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_rel_rsp_valid", 32'(rv_m), 32'd0);
    check("bp_rel_req_ready", 32'(rq_m), 32'd1);
    run_op("bp_sw30", 1'b1, 32'h30, 32'h77, 2'd2, 1'b0, rd);
    run_op("bp_lw30", 1'b0, 32'h30, 32'h0, 2'd2, 1'b0, rd);
    check("bp_lw30_const", rd, 32'h77);

    reset_during_store(1'b0);
    random_ops(300);

    // LATENCY = 0 instance
    sel = 1'b1;
    @(negedge clk);
    init_mem();
    run_op("l0_sw10", 1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0, rd);
    run_op("l0_sb13", 1'b1, 32'h13, 32'h80, 2'd0, 1'b0, rd);
    run_op("l0_lw10", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, rd);
    check("l0_lw10_const", rd, 32'h80AD_BEEF);
    run_op("l0_lhu12", 1'b0, 32'h12, 32'h0, 2'd1, 1'b1, rd);
    check("l0_lhu12_const", rd, 32'h0000_80AD);
    run_op("l0_lw11", 1'b0, 32'h11, 32'h0, 2'd2, 1'b0, rd);
    reset_during_store(1'b1);
    random_ops(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
